// File: rtl/ddr_block_port.sv
// CPU block port for a DDR2 controller's native user interface: each request moves one
// 256-bit block as two 128-bit beats, with a level request and a one-cycle done pulse.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// S_IDLE    | waiting for ram_en with calibration complete
// S_WRITE   | command and write-data handshakes for beat r_beat
// S_RD_CMD  | issuing read commands for beat 0 then beat 1
// S_RD_DATA | both read commands accepted, collecting remaining read beats
// S_DONE    | ram_rdy high for this single cycle
module ddr_block_port #(
  parameter int ADDR_W      = 27,
  parameter int BEAT_STRIDE = 8
) (
  input  logic              clk_from_ip,
  input  logic              rst,
  input  logic              ram_en,
  input  logic              ram_write,
  input  logic [29:0]       ram_addr,
  input  logic [255:0]      data_to_ram,
  output logic              ram_rdy,
  output logic [255:0]      block_out,
  output logic              ui_clk,
  input  logic              init_calib_complete,
  output logic [ADDR_W-1:0] app_addr,
  output logic [2:0]        app_cmd,
  output logic              app_en,
  input  logic              app_rdy,
  output logic [127:0]      app_wdf_data,
  output logic              app_wdf_wren,
  output logic              app_wdf_end,
  input  logic              app_wdf_rdy,
  input  logic [127:0]      app_rd_data,
  input  logic              app_rd_data_valid
);

  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_RD_CMD,
    S_RD_DATA,
    S_DONE
  } state_t;

  state_t              r_state;
  logic                r_beat;
  logic                r_cmd_done;
  logic                r_wdf_done;
  logic [1:0]          r_rd_cnt;
  logic [ADDR_W-1:0]   r_addr1;
  logic [127:0]        r_wdata_hi;

  logic [ADDR_W-1:0]   w_addr0;
  logic                w_cmd_hs;
  logic                w_wdf_hs;
  logic                w_cmd_ok;
  logic                w_wdf_ok;
  logic                w_rd_beat;
  logic [1:0]          w_rd_cnt_nxt;

  assign ui_clk       = clk_from_ip;
  assign app_wdf_end  = app_wdf_wren;

  assign w_addr0      = ADDR_W'({ram_addr, 4'b0000});
  assign w_cmd_hs     = app_en & app_rdy;
  assign w_wdf_hs     = app_wdf_wren & app_wdf_rdy;
  assign w_cmd_ok     = r_cmd_done | w_cmd_hs;
  assign w_wdf_ok     = r_wdf_done | w_wdf_hs;
  // Read beats can return while the second read command is still pending.
  assign w_rd_beat    = app_rd_data_valid && (r_rd_cnt != 2'd2) &&
                        ((r_state == S_RD_CMD) || (r_state == S_RD_DATA));
  assign w_rd_cnt_nxt = r_rd_cnt + {1'b0, w_rd_beat};

  always_ff @(posedge clk_from_ip) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_beat       <= 1'b0;
      r_cmd_done   <= 1'b0;
      r_wdf_done   <= 1'b0;
      r_rd_cnt     <= 2'd0;
      r_addr1      <= '0;
      r_wdata_hi   <= '0;
      ram_rdy      <= 1'b0;
      block_out    <= '0;
      app_addr     <= '0;
      app_cmd      <= CMD_WR;
      app_en       <= 1'b0;
      app_wdf_data <= '0;
      app_wdf_wren <= 1'b0;
    end else begin
      if (w_rd_beat) begin
        if (r_rd_cnt == 2'd0) block_out[127:0]   <= app_rd_data;
        else                  block_out[255:128] <= app_rd_data;
        r_rd_cnt <= w_rd_cnt_nxt;
      end

      case (r_state)
        S_IDLE: begin
          if (ram_en && init_calib_complete) begin
            r_beat     <= 1'b0;
            r_cmd_done <= 1'b0;
            r_wdf_done <= 1'b0;
            r_rd_cnt   <= 2'd0;
            r_addr1    <= w_addr0 + ADDR_W'(BEAT_STRIDE);
            r_wdata_hi <= data_to_ram[255:128];
            app_addr   <= w_addr0;
            app_en     <= 1'b1;
            if (ram_write) begin
              app_cmd      <= CMD_WR;
              app_wdf_data <= data_to_ram[127:0];
              app_wdf_wren <= 1'b1;
              r_state      <= S_WRITE;
            end else begin
              app_cmd <= CMD_RD;
              r_state <= S_RD_CMD;
            end
          end
        end

        S_WRITE: begin
          if (w_cmd_ok && w_wdf_ok) begin
            r_cmd_done <= 1'b0;
            r_wdf_done <= 1'b0;
            if (!r_beat) begin
              r_beat       <= 1'b1;
              app_addr     <= r_addr1;
              app_wdf_data <= r_wdata_hi;
              app_en       <= 1'b1;
              app_wdf_wren <= 1'b1;
            end else begin
              app_en       <= 1'b0;
              app_wdf_wren <= 1'b0;
              ram_rdy      <= 1'b1;
              r_state      <= S_DONE;
            end
          end else begin
            // Command and data channels retire independently; remember which side is done.
            if (w_cmd_hs) begin
              app_en     <= 1'b0;
              r_cmd_done <= 1'b1;
            end
            if (w_wdf_hs) begin
              app_wdf_wren <= 1'b0;
              r_wdf_done   <= 1'b1;
            end
          end
        end

        S_RD_CMD: begin
          if (w_cmd_hs) begin
            if (!r_beat) begin
              r_beat   <= 1'b1;
              app_addr <= r_addr1;
            end else begin
              app_en <= 1'b0;
              if (w_rd_cnt_nxt == 2'd2) begin
                ram_rdy <= 1'b1;
                r_state <= S_DONE;
              end else begin
                r_state <= S_RD_DATA;
              end
            end
          end
        end

        S_RD_DATA: begin
          if (w_rd_cnt_nxt == 2'd2) begin
            ram_rdy <= 1'b1;
            r_state <= S_DONE;
          end
        end

        S_DONE: begin
          ram_rdy <= 1'b0;
          r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_block_port.sv
// Bench for ddr_block_port: a per-cycle vector table for the basic write/read flow, then
// hand-written sequences against a small controller model for stalls, calibration, b2b, reset.
module tb_ddr_block_port;

  logic           clk = 1'b0;
  logic           rst;
  logic           ram_en;
  logic           ram_write;
  logic [29:0]    ram_addr;
  logic [255:0]   data_to_ram;
  logic           ram_rdy;
  logic [255:0]   block_out;
  logic           ui_clk_w;
  logic           init_calib_complete;
  logic [26:0]    app_addr;
  logic [2:0]     app_cmd;
  logic           app_en;
  logic           app_rdy;
  logic [127:0]   app_wdf_data;
  logic           app_wdf_wren;
  logic           app_wdf_end;
  logic           app_wdf_rdy;
  logic [127:0]   app_rd_data;
  logic           app_rd_data_valid;

  always #5 clk = ~clk;

  ddr_block_port #(.ADDR_W(27), .BEAT_STRIDE(8)) dut (
    .clk_from_ip(clk), .rst(rst), .ram_en(ram_en), .ram_write(ram_write),
    .ram_addr(ram_addr), .data_to_ram(data_to_ram), .ram_rdy(ram_rdy),
    .block_out(block_out), .ui_clk(ui_clk_w), .init_calib_complete(init_calib_complete),
    .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
    .app_wdf_data(app_wdf_data), .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
    .app_wdf_rdy(app_wdf_rdy), .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid)
  );

  typedef struct {
    logic         rst, en, wr;
    logic [29:0]  addr;
    logic [255:0] wdata;
    logic         ardy, wrdy, rvalid;
    logic [127:0] rdata;
    logic         calib;
    logic         e_rdy, e_en;
    logic [2:0]   e_cmd;
    logic [26:0]  e_addr;
    logic         e_wren;
    logic [127:0] e_wdf;
    logic [255:0] e_blk;
  } vec_t;

  vec_t vecs[$];

  int n_vec  = 0;
  int n_miss = 0;

  // controller model state
  int           cyc = 0;
  int           stall_c = 0;
  int           n_cmd = 0, n_wdf = 0, n_rdy = 0;
  int           wq_a[$];
  logic [127:0] wq_d[$];
  int           rq_due[$];
  int           rq_a[$];
  logic [127:0] mem [int];

  function automatic vec_t mk(input logic r, en, wr, input logic [29:0] addr,
                              input logic [255:0] wdata, input logic ardy, wrdy, rv,
                              input logic [127:0] rdata, input logic calib,
                              input logic e_rdy, e_en, input logic [2:0] e_cmd,
                              input logic [26:0] e_addr, input logic e_wren,
                              input logic [127:0] e_wdf, input logic [255:0] e_blk);
    vec_t v;
    v.rst = r; v.en = en; v.wr = wr; v.addr = addr; v.wdata = wdata;
    v.ardy = ardy; v.wrdy = wrdy; v.rvalid = rv; v.rdata = rdata; v.calib = calib;
    v.e_rdy = e_rdy; v.e_en = e_en; v.e_cmd = e_cmd; v.e_addr = e_addr;
    v.e_wren = e_wren; v.e_wdf = e_wdf; v.e_blk = e_blk;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One clock with the controller model reacting to handshakes seen at that edge.
  task automatic tick();
    logic         hs_c, hs_w;
    logic [2:0]   cmd;
    int           a, ra;
    logic [127:0] wd;
    hs_c = app_en & app_rdy;
    hs_w = app_wdf_wren & app_wdf_rdy;
    cmd  = app_cmd;
    a    = int'(app_addr);
    wd   = app_wdf_data;
    @(posedge clk);
    #1;
    cyc++;
    if (hs_c) begin
      n_cmd++;
      if (cmd == 3'b000) wq_a.push_back(a);
      else begin
        rq_due.push_back(cyc + 2);
        rq_a.push_back(a);
      end
    end
    if (hs_w) begin
      n_wdf++;
      wq_d.push_back(wd);
    end
    while (wq_a.size() > 0 && wq_d.size() > 0) mem[wq_a.pop_front()] = wq_d.pop_front();
    if (ram_rdy) n_rdy++;
    app_rd_data_valid = 1'b0;
    if (rq_due.size() > 0 && rq_due[0] <= cyc) begin
      void'(rq_due.pop_front());
      ra = rq_a.pop_front();
      app_rd_data_valid = 1'b1;
      app_rd_data = mem.exists(ra) ? mem[ra] : 128'h0;
    end
    app_rdy = (stall_c > 0) ? 1'b0 : 1'b1;
    if (stall_c > 0) stall_c--;
  endtask

  task automatic wait_rdy(input string nm);
    for (int k = 0; k < 40 && !ram_rdy; k++) tick();
    chk(nm, ram_rdy, 1'b1);
  endtask

  initial begin
    logic         saw;
    logic [255:0] one_blk;
    one_blk = 256'h1;

    //        rst en wr addr  wdata   ardy wrdy rv rdata calib | rdy en cmd addr wren wdf blk
    vecs.push_back(mk(1,0,0, 30'h0, 256'h0, 1,1,0, 128'h0, 1,   0,0,3'b000,27'h00,0,128'h0,256'h0));
    vecs.push_back(mk(0,1,1, 30'h8, 256'h1, 1,1,0, 128'h0, 1,   0,1,3'b000,27'h80,1,128'h1,256'h0));
    vecs.push_back(mk(0,1,1, 30'h3, {256{1'b1}}, 1,1,0, 128'h0, 1, 0,1,3'b000,27'h88,1,128'h0,256'h0));
    vecs.push_back(mk(0,1,1, 30'h3, {256{1'b1}}, 1,1,0, 128'h0, 1, 1,0,3'b000,27'h88,0,128'h0,256'h0));
    vecs.push_back(mk(0,0,1, 30'h8, 256'h1, 1,1,0, 128'h0, 1,   0,0,3'b000,27'h88,0,128'h0,256'h0));
    vecs.push_back(mk(0,0,1, 30'h8, 256'h1, 1,1,0, 128'h0, 1,   0,0,3'b000,27'h88,0,128'h0,256'h0));
    vecs.push_back(mk(0,1,0, 30'h8, 256'h0, 1,1,0, 128'h0, 1,   0,1,3'b001,27'h80,0,128'h0,256'h0));
    vecs.push_back(mk(0,1,0, 30'h8, 256'h0, 1,1,0, 128'h0, 1,   0,1,3'b001,27'h88,0,128'h0,256'h0));
    vecs.push_back(mk(0,1,0, 30'h8, 256'h0, 1,1,0, 128'h0, 1,   0,0,3'b001,27'h88,0,128'h0,256'h0));
    vecs.push_back(mk(0,1,0, 30'h8, 256'h0, 1,1,0, 128'h0, 1,   0,0,3'b001,27'h88,0,128'h0,256'h0));
    vecs.push_back(mk(0,1,0, 30'h8, 256'h0, 1,1,1, 128'h01, 1,  0,0,3'b001,27'h88,0,128'h0,256'h1));
    vecs.push_back(mk(0,1,0, 30'h8, 256'h0, 1,1,1, 128'hAA, 1,  1,0,3'b001,27'h88,0,128'h0,{128'hAA,128'h01}));
    vecs.push_back(mk(0,0,0, 30'h8, 256'h0, 1,1,1, 128'hFF, 1,  0,0,3'b001,27'h88,0,128'h0,{128'hAA,128'h01}));
    vecs.push_back(mk(0,0,0, 30'h8, 256'h0, 1,1,0, 128'h0, 1,   0,0,3'b001,27'h88,0,128'h0,{128'hAA,128'h01}));
    vecs.push_back(mk(0,1,1, 30'h2, 256'h5, 1,1,0, 128'h0, 0,   0,0,3'b001,27'h88,0,128'h0,{128'hAA,128'h01}));
    vecs.push_back(mk(0,1,1, 30'h2, 256'h5, 1,1,0, 128'h0, 0,   0,0,3'b001,27'h88,0,128'h0,{128'hAA,128'h01}));
    vecs.push_back(mk(0,0,1, 30'h2, 256'h5, 1,1,0, 128'h0, 1,   0,0,3'b001,27'h88,0,128'h0,{128'hAA,128'h01}));

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; ram_en = vecs[i].en; ram_write = vecs[i].wr;
      ram_addr = vecs[i].addr; data_to_ram = vecs[i].wdata;
      app_rdy = vecs[i].ardy; app_wdf_rdy = vecs[i].wrdy;
      app_rd_data_valid = vecs[i].rvalid; app_rd_data = vecs[i].rdata;
      init_calib_complete = vecs[i].calib;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_ctrl", i),
          {ram_rdy, app_en, app_cmd, app_wdf_wren, app_wdf_end, app_addr},
          {vecs[i].e_rdy, vecs[i].e_en, vecs[i].e_cmd, vecs[i].e_wren, vecs[i].e_wren, vecs[i].e_addr});
      chk($sformatf("vec%0d_wdf", i), app_wdf_data, vecs[i].e_wdf);
      chk($sformatf("vec%0d_blk", i), block_out, vecs[i].e_blk);
    end

    // Write with the data channel ready before the command channel.
    app_rd_data_valid = 1'b0; app_rd_data = '0; app_wdf_rdy = 1'b1; init_calib_complete = 1'b1;
    ram_en = 1'b0; rst = 1'b1; tick(); rst = 1'b0;
    app_rdy = 1'b0; stall_c = 4;
    ram_en = 1'b1; ram_write = 1'b1; ram_addr = 30'h10; data_to_ram = {128'h22, 128'h11};
    n_cmd = 0; n_wdf = 0; n_rdy = 0;
    tick();
    repeat (4) tick();
    chk("stall_wdf_beats", n_wdf, 1);
    chk("stall_cmd_beats", n_cmd, 0);
    chk("stall_no_rdy", n_rdy, 0);
    chk("stall_wren_dropped", app_wdf_wren, 1'b0);
    chk("stall_en_held", app_en, 1'b1);
    wait_rdy("stall_done");
    ram_en = 1'b0;
    chk("stall_cmd_total", n_cmd, 2);
    chk("stall_wdf_total", n_wdf, 2);
    tick();
    chk("stall_rdy_pulse", {ram_rdy, 8'(n_rdy)}, {1'b0, 8'd1});
    chk("stall_mem_beat0", mem.exists(32'h100) ? mem[32'h100] : 128'hX, 128'h11);
    chk("stall_mem_beat1", mem.exists(32'h108) ? mem[32'h108] : 128'hX, 128'h22);

    // Request held while calibration is still running.
    init_calib_complete = 1'b0;
    ram_en = 1'b1; ram_write = 1'b0; ram_addr = 30'h10;
    saw = 1'b0;
    repeat (10) begin
      tick();
      saw |= app_en;
    end
    chk("calib_no_app_en", saw, 1'b0);
    init_calib_complete = 1'b1;
    tick();
    chk("calib_start", {app_en, app_cmd}, {1'b1, 3'b001});
    wait_rdy("calib_read_done");
    ram_en = 1'b0;
    chk("calib_read_blk", block_out, {128'h22, 128'h11});
    tick();
    chk("calib_rdy_drop", ram_rdy, 1'b0);

    // Back-to-back write then read, direction flipped on the ram_rdy edge.
    ram_en = 1'b1; ram_write = 1'b1; ram_addr = 30'h8; data_to_ram = 256'h1;
    wait_rdy("b2b_write_done");
    ram_write = 1'b0;
    tick();
    tick();
    chk("b2b_read_start", {app_en, app_cmd, app_addr}, {1'b1, 3'b001, 27'h80});
    wait_rdy("b2b_read_done");
    ram_en = 1'b0;
    chk("b2b_blk_byte", block_out[7:0], 8'h01);
    chk("b2b_blk", block_out, one_blk);

    // Reset after the first read beat lands; the second beat arrives with reset.
    tick();
    ram_en = 1'b1; ram_write = 1'b0; ram_addr = 30'h10;
    for (int k = 0; k < 40 && block_out[127:0] !== 128'h11; k++) tick();
    chk("rst_first_beat", block_out[127:0], 128'h11);
    n_rdy = 0;
    rst = 1'b1; ram_en = 1'b0;
    tick();
    rst = 1'b0;
    chk("rst_ctrl", {ram_rdy, app_en, app_cmd, app_wdf_wren, app_addr}, 33'h0);
    chk("rst_blk", block_out, 256'h0);
    saw = 1'b0;
    repeat (6) begin
      tick();
      saw |= (ram_rdy | app_en | (block_out != 256'h0));
    end
    chk("rst_late_beat_ignored", {saw, 8'(n_rdy)}, 9'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
